// File: rtl/r2sdf_ctrl.sv
// ---------------------------------------------------------------------------
// r2sdf_ctrl
// Sequencer for a radix-2 single-delay-feedback FFT pipeline of 2^N points
// spread over N stages. It accepts a frame start pulse and produces the
// per-stage butterfly selects, the twiddle enables and exponents, the output
// valid flag with its bit-reversed bin index, a busy flag and a sticky error
// flag for badly timed starts. Back-to-back frames stream without gaps.
//
// Parameters
//   N            log2 of the FFT length; stage s has feedback delay 2^(N-1-s)
//   PIPE_LAT     extra datapath register cycles after the last stage
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_start_ip   frame start; sample 0 enters on the cycle after it is sampled
//   o_stage_bf   bit s = stage s in butterfly mode (0 = fill/pass)
//   o_tw_en      bit s = stage s output is multiplied by a twiddle (s < N-1)
//   o_tw_exp     packed N-1 fields of N-1 bits; field s = twiddle exponent
//   o_op_valid   datapath output carries a valid bin this cycle
//   o_op_idx     bit-reversed bin index of the current output
//   o_busy       some valid sample is still in flight
//   o_start_err  sticky: a start arrived when it could not be accepted
// ---------------------------------------------------------------------------
module r2sdf_ctrl #(
    parameter int N        = 4,
    parameter int PIPE_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start_ip,
    output logic [N-1:0]           o_stage_bf,
    output logic [N-2:0]           o_tw_en,
    output logic [(N-1)*(N-1)-1:0] o_tw_exp,
    output logic                   o_op_valid,
    output logic [N-1:0]           o_op_idx,
    output logic                   o_busy,
    output logic                   o_start_err
);

    localparam int L     = 1 << N;
    localparam int TW    = N - 1;
    localparam int DEPTH = L + PIPE_LAT;
    localparam logic [N-1:0] LAST    = N'(L - 1);
    // Output ordinal j is the global count minus this offset (mod 2^N).
    localparam logic [N-1:0] OUT_OFS = N'(L - 1 + PIPE_LAT);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [N-1:0]         r_cnt;
    logic [N-1:0]         w_cntNext;
    // r_vhist[i] is "stage 0 took a valid sample i cycles ago".
    logic [DEPTH-2:0]     r_vhist;
    logic [DEPTH-1:0]     w_vhistNext;
    logic                 w_startBad;

    logic [N-1:0]         w_cs;
    logic [N-1:0]         w_j;
    logic [N-1:0]         w_stageBf;
    logic [N-2:0]         w_twEn;
    logic [TW*TW-1:0]     w_twExp;
    logic                 w_opValid;
    logic [N-1:0]         w_opIdx;

    // Next-state logic. The global counter free-runs outside IDLE, so frames
    // chained from the last LOAD cycle stay aligned to it without a reload.
    // w_vhistNext is the valid history as it will look next cycle, with
    // index 0 being "a sample enters stage 0 next cycle".
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = (r_state == IDLE) ? r_cnt : r_cnt + N'(1);
        w_startBad  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start_ip) begin
                    w_stateNext = LOAD;
                    w_cntNext   = '0;
                end
            end
            LOAD: begin
                if (r_cnt == LAST) begin
                    if (!i_start_ip) begin
                        w_stateNext = DRAIN;
                    end
                end else if (i_start_ip) begin
                    w_startBad = 1'b1;
                end
            end
            DRAIN: begin
                if (i_start_ip) begin
                    w_startBad = 1'b1;
                end
                // Nothing left in the history means busy drops next cycle.
                if (r_vhist == '0) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
        w_vhistNext = {r_vhist, w_stateNext == LOAD};
    end

    // Output decode from next-cycle state so every output can be registered.
    // Stage s sees the sample that entered stage 0 O_s = 2^N - 2^(N-s) cycles
    // earlier; its delay line emits a difference term when the sample that
    // entered it D_s cycles ago (O_(s+1) cycles back at stage 0) is valid.
    always_comb begin
        w_cs      = '0;
        w_stageBf = '0;
        w_twEn    = '0;
        w_twExp   = '0;
        for (int s = 0; s < N; s++) begin
            w_cs         = w_cntNext - N'(L - (L >> s));
            w_stageBf[s] = w_vhistNext[L - (L >> s)] & w_cs[N-1-s];
        end
        for (int s = 0; s < N - 1; s++) begin
            w_cs = w_cntNext - N'(L - (L >> s));
            if (w_vhistNext[L - (L >> (s + 1))] && !w_cs[N-1-s]) begin
                w_twEn[s]               = 1'b1;
                w_twExp[s*TW +: TW]     = TW'((w_cs & N'((L >> (s + 1)) - 1)) << s);
            end
        end
        w_opValid = w_vhistNext[DEPTH-1];
        w_j       = w_cntNext - OUT_OFS;
        w_opIdx   = '0;
        if (w_opValid) begin
            for (int b = 0; b < N; b++) begin
                w_opIdx[b] = w_j[N-1-b];
            end
        end
    end

    // Single state register block: FSM, counter, valid history and all
    // registered outputs. Reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_vhist     <= '0;
            o_stage_bf  <= '0;
            o_tw_en     <= '0;
            o_tw_exp    <= '0;
            o_op_valid  <= 1'b0;
            o_op_idx    <= '0;
            o_busy      <= 1'b0;
            o_start_err <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_vhist     <= w_vhistNext[DEPTH-2:0];
            o_stage_bf  <= w_stageBf;
            o_tw_en     <= w_twEn;
            o_tw_exp    <= w_twExp;
            o_op_valid  <= w_opValid;
            o_op_idx    <= w_opIdx;
            o_busy      <= |w_vhistNext;
            o_start_err <= o_start_err | w_startBad;
        end
    end

endmodule
